// File: rtl/lcd_bus_sched_if.sv
// lcd_bus_sched_if: bundles the two byte requester handshakes and the
// character-LCD pin/status signals shared by lcd_bus_sched.
//   master : requester/pin-side view (drives requests, observes LCD pins)
//   slave  : scheduler view (accepts requests, drives LCD pins + status)
interface lcd_bus_sched_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       lcd_e;
  logic       lcd_rs;
  logic [3:0] lcd_d;
  logic       init_done;
  logic       busy;

  modport master (
    output req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready, lcd_e, lcd_rs, lcd_d, init_done, busy
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready, lcd_e, lcd_rs, lcd_d, init_done, busy
  );
endinterface

// File: rtl/lcd_bus_sched.sv
// lcd_bus_sched: controller/arbiter for a shared 4-bit HD44780-style LCD bus.
// Runs the power-on nibble init (3,3,3,2), then arbitrates two byte
// requesters and sends each byte as high/low nibble with timed E strobes.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active high
//   bus  - lcd_bus_sched_if.slave: req0/req1 valid/rs/data/ready,
//          lcd_e/lcd_rs/lcd_d, init_done, busy
// Build option: define LCD_ROUNDROBIN_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module lcd_bus_sched #(
  parameter int E_HIGH_CYC    = 16,
  parameter int NIB_GAP_CYC   = 32,
  parameter int CMD_WAIT_CYC  = 64,
  parameter int CLR_WAIT_CYC  = 2048,
  parameter int INIT_WAIT_CYC = 4096
) (
  input logic            clk,
  input logic            rst,
  lcd_bus_sched_if.slave bus
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(max_of(E_HIGH_CYC, NIB_GAP_CYC),
                                         max_of(CMD_WAIT_CYC, CLR_WAIT_CYC)),
                                  INIT_WAIT_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);
  typedef logic [CW-1:0] cnt_t;

  // Counters load N-1 on entry and leave the state at zero: N cycles.
  localparam cnt_t E_LD    = cnt_t'(E_HIGH_CYC - 1);
  localparam cnt_t GAP_LD  = cnt_t'(NIB_GAP_CYC - 1);
  localparam cnt_t CMD_LD  = cnt_t'(CMD_WAIT_CYC - 1);
  localparam cnt_t CLR_LD  = cnt_t'(CLR_WAIT_CYC - 1);
  localparam cnt_t PWR_LD  = cnt_t'(INIT_WAIT_CYC - 1);

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_NIB, IDLE, SETUP_HI, PULSE_HI, GAP, SETUP_LO, PULSE_LO,
    POST_WAIT
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_WAIT} phase_t;

  state_t     state, state_n;
  cnt_t       cnt, cnt_n;
  logic [1:0] nib, nib_n;
  phase_t     phase, phase_n;
  logic       cap_rs, cap_rs_n;
  logic [7:0] cap_data, cap_data_n;

  logic       e_q, e_n;
  logic       rs_q, rs_n;
  logic [3:0] d_q, d_n;
  logic       done_q, done_n;
  logic       busy_q, busy_n;

  logic       ready0, ready1;
  logic       is_clr;

`ifdef LCD_ROUNDROBIN_EN
  logic rr, rr_n;  // requester that wins a simultaneous request
`endif

  // Arbitration: only IDLE grants; IDLE is reachable only after init.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (state == IDLE) begin
`ifdef LCD_ROUNDROBIN_EN
      ready0 = bus.req0_valid & (~bus.req1_valid | ~rr);
      ready1 = bus.req1_valid & (~bus.req0_valid |  rr);
`else
      ready0 = bus.req0_valid;
      ready1 = bus.req1_valid & ~bus.req0_valid;
`endif
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  // Clear/home commands need the long post-byte wait.
  assign is_clr = ~cap_rs && (cap_data[7:2] == 6'd0) && (cap_data[1:0] != 2'd0);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PWR_WAIT;
      cnt      <= PWR_LD;
      nib      <= 2'd0;
      phase    <= PH_SETUP;
      cap_rs   <= 1'b0;
      cap_data <= 8'd0;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      d_q      <= 4'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
`ifdef LCD_ROUNDROBIN_EN
      rr       <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      nib      <= nib_n;
      phase    <= phase_n;
      cap_rs   <= cap_rs_n;
      cap_data <= cap_data_n;
      e_q      <= e_n;
      rs_q     <= rs_n;
      d_q      <= d_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
`ifdef LCD_ROUNDROBIN_EN
      rr       <= rr_n;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_n    = state;
    cnt_n      = (cnt == '0) ? cnt : cnt - 1'b1;
    nib_n      = nib;
    phase_n    = phase;
    cap_rs_n   = cap_rs;
    cap_data_n = cap_data;
`ifdef LCD_ROUNDROBIN_EN
    rr_n       = rr;
`endif
    case (state)
      PWR_WAIT: if (cnt == '0) begin
        state_n = INIT_NIB;
        phase_n = PH_SETUP;
        nib_n   = 2'd0;
        cnt_n   = '0;
      end
      INIT_NIB: if (cnt == '0) begin
        case (phase)
          PH_SETUP: begin phase_n = PH_HIGH; cnt_n = E_LD;   end
          PH_HIGH:  begin phase_n = PH_WAIT; cnt_n = CMD_LD; end
          default: begin
            if (nib == 2'd3) begin
              state_n = IDLE;
            end else begin
              nib_n   = nib + 2'd1;
              phase_n = PH_SETUP;
              cnt_n   = '0;
            end
          end
        endcase
      end
      IDLE: if (ready0 || ready1) begin
        state_n    = SETUP_HI;
        cnt_n      = '0;
        cap_rs_n   = ready1 ? bus.req1_rs   : bus.req0_rs;
        cap_data_n = ready1 ? bus.req1_data : bus.req0_data;
`ifdef LCD_ROUNDROBIN_EN
        rr_n       = ready0;
`endif
      end
      SETUP_HI:  begin state_n = PULSE_HI; cnt_n = E_LD; end
      PULSE_HI:  if (cnt == '0) begin state_n = GAP; cnt_n = GAP_LD; end
      GAP:       if (cnt == '0) begin state_n = SETUP_LO; cnt_n = '0; end
      SETUP_LO:  begin state_n = PULSE_LO; cnt_n = E_LD; end
      PULSE_LO:  if (cnt == '0) begin
        state_n = POST_WAIT;
        cnt_n   = is_clr ? CLR_LD : CMD_LD;
      end
      POST_WAIT: if (cnt == '0) state_n = IDLE;
      default:   state_n = PWR_WAIT;
    endcase
  end

  // Output logic: registered outputs follow the state being entered, so
  // pins line up with the state they belong to. lcd_d/lcd_rs change only
  // at setup states, which keeps them stable through a pulse and after it.
  always_comb begin
    e_n    = 1'b0;
    rs_n   = rs_q;
    d_n    = d_q;
    busy_n = (state_n != IDLE);
    done_n = done_q | (state_n == IDLE);
    case (state_n)
      INIT_NIB: begin
        rs_n = 1'b0;
        d_n  = (nib_n == 2'd3) ? 4'h2 : 4'h3;
        e_n  = (phase_n == PH_HIGH);
      end
      SETUP_HI: begin
        rs_n = cap_rs_n;
        d_n  = cap_data_n[7:4];
      end
      SETUP_LO: d_n = cap_data_n[3:0];
      PULSE_HI, PULSE_LO: e_n = 1'b1;
      default: ;
    endcase
  end

  assign bus.lcd_e     = e_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_d     = d_q;
  assign bus.init_done = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Directed bench for lcd_bus_sched with short timing parameters
// (E=2, GAP=3, CMD=4, CLR=20, INIT=10).
module tb_lcd_bus_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_sched_if bus();

  lcd_bus_sched #(
    .E_HIGH_CYC(2), .NIB_GAP_CYC(3), .CMD_WAIT_CYC(4),
    .CLR_WAIT_CYC(20), .INIT_WAIT_CYC(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef LCD_ROUNDROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit exp_rr = 1'b0;  // expected winner of the next simultaneous request

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle with rst low; walks to the first IDLE cycle.
  // Init nibble k has its setup at cycle 10+7k, E high at 11+7k and 12+7k.
  task automatic check_init();
    for (int i = 1; i <= 38; i++) begin
      tick();
      chk($sformatf("init_e[%0d]", i), 32'(bus.lcd_e),
          32'(i >= 11 && i <= 33 && (i % 7 == 4 || i % 7 == 5)));
      chk($sformatf("init_d[%0d]", i), 32'(bus.lcd_d),
          (i < 10) ? 32'd0 : (i < 31) ? 32'd3 : 32'd2);
      chk($sformatf("init_rs[%0d]", i), 32'(bus.lcd_rs), 32'd0);
      chk($sformatf("init_busy[%0d]", i), 32'(bus.busy), 32'(i < 38));
      chk($sformatf("init_done[%0d]", i), 32'(bus.init_done), 32'(i == 38));
      if (i < 38) begin
        chk($sformatf("init_rdy0[%0d]", i), 32'(bus.req0_ready), 32'd0);
        chk($sformatf("init_rdy1[%0d]", i), 32'(bus.req1_ready), 32'd0);
      end
    end
  endtask

  // In an IDLE cycle: raise the requester's valid, expect the grant, clock it.
  task automatic handshake(input int who, input logic rs, input logic [7:0] data);
    if (who == 0) begin
      bus.req0_valid = 1'b1; bus.req0_rs = rs; bus.req0_data = data;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_rs = rs; bus.req1_data = data;
    end
    #1;
    chk("hs_rdy0", 32'(bus.req0_ready), 32'(who == 0));
    chk("hs_rdy1", 32'(bus.req1_ready), 32'(who == 1));
    tick();
    if (who == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    exp_rr = (who == 0);
  endtask

  // Called in the first cycle after a handshake; walks to the next IDLE cycle.
  // Layout: 1 setup, 2 E high, 3 gap, 1 setup, 2 E high, wt post-wait.
  task automatic check_byte(input logic rs, input logic [7:0] data, input int wt);
    for (int j = 1; j <= 10 + wt; j++) begin
      if (j > 1) tick();
      chk($sformatf("byte%02h_e[%0d]", data, j), 32'(bus.lcd_e),
          32'(j == 2 || j == 3 || j == 8 || j == 9));
      chk($sformatf("byte%02h_d[%0d]", data, j), 32'(bus.lcd_d),
          (j <= 6) ? 32'(data[7:4]) : 32'(data[3:0]));
      chk($sformatf("byte%02h_rs[%0d]", data, j), 32'(bus.lcd_rs), 32'(rs));
      chk($sformatf("byte%02h_busy[%0d]", data, j), 32'(bus.busy), 32'(j < 10 + wt));
      if (j < 10 + wt) begin
        chk($sformatf("byte%02h_rdy0[%0d]", data, j), 32'(bus.req0_ready), 32'd0);
        chk($sformatf("byte%02h_rdy1[%0d]", data, j), 32'(bus.req1_ready), 32'd0);
      end
    end
  endtask

  initial begin
    int c0, c1, w;
    logic [7:0] bd;
    bus.req0_valid = 1'b0; bus.req0_rs = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_rs = 1'b0; bus.req1_data = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_e", 32'(bus.lcd_e), 32'd0);
    chk("rst_d", 32'(bus.lcd_d), 32'd0);
    chk("rst_rs", 32'(bus.lcd_rs), 32'd0);
    chk("rst_done", 32'(bus.init_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_rdy0", 32'(bus.req0_ready), 32'd0);
    chk("rst_rdy1", 32'(bus.req1_ready), 32'd0);

    // Power-on init with no requests
    rst = 1'b0;
    check_init();

    // Data byte from req0
    handshake(0, 1'b1, 8'h48);
    check_byte(1'b1, 8'h48, 4);

    // Clear command from req1; req0 waits behind it for the long post-wait
    handshake(1, 1'b0, 8'h01);
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h30;
    check_byte(1'b0, 8'h01, 20);
    handshake(0, 1'b1, 8'h30);
    check_byte(1'b1, 8'h30, 4);

    // Both requesters hold valid for 4 bytes each
    c0 = 0; c1 = 0;
    for (int k = 0; k < 8; k++) begin
      bus.req0_valid = (c0 < 4); bus.req0_rs = 1'b1; bus.req0_data = 8'hA0 + 8'(c0);
      bus.req1_valid = (c1 < 4); bus.req1_rs = 1'b1; bus.req1_data = 8'hB0 + 8'(c1);
      #1;
      if (c0 < 4 && c1 < 4) w = RR_EN ? int'(exp_rr) : 0;
      else                  w = (c0 < 4) ? 0 : 1;
      chk($sformatf("arb_rdy0[%0d]", k), 32'(bus.req0_ready), 32'(w == 0));
      chk($sformatf("arb_rdy1[%0d]", k), 32'(bus.req1_ready), 32'(w == 1));
      tick();
      exp_rr = (w == 0);
      if (w == 1) begin bd = 8'hB0 + 8'(c1); c1++; end
      else        begin bd = 8'hA0 + 8'(c0); c0++; end
      check_byte(1'b1, bd, 4);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // Reset during PULSE_LO aborts the byte; req0 pending across re-init
    handshake(0, 1'b1, 8'h5A);
    repeat (7) tick();
    chk("abort_in_pulse_lo", 32'(bus.lcd_e), 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_e", 32'(bus.lcd_e), 32'd0);
    chk("abort_d", 32'(bus.lcd_d), 32'd0);
    chk("abort_rs", 32'(bus.lcd_rs), 32'd0);
    chk("abort_done", 32'(bus.init_done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h77;
    check_init();
    handshake(0, 1'b1, 8'h77);
    check_byte(1'b1, 8'h77, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
